// File: rtl/codeword_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// codeword_deserializer_pkg
// Shared definitions for the self-correcting message path: the collector FSM
// state type and the codeword geometry constants. The transmit-side
// bit-select stage and the decoder use the same constants.
// ---------------------------------------------------------------------------
package codeword_deserializer_pkg;

   // 15-bit Hamming codeword plus one overall parity bit
   localparam int CW_WIDTH = 16;
   localparam int CW_IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } cw_state_t;

endpackage

// File: rtl/codeword_deserializer_if.sv
// ---------------------------------------------------------------------------
// codeword_deserializer_if
// Serial-in / word-out bundle of the codeword collector.
//   in_valid, in_bit, in_sof, in_ready : serial bit handshake
//   out_valid, out_ready, out_word     : completed codeword handshake
//   bit_idx                            : position the next accepted bit fills
//   frame_err                          : one-cycle abort / stray-bit pulse
// Modports: master drives the serial side and consumes words; slave is the
// collector itself.
// ---------------------------------------------------------------------------
interface codeword_deserializer_if
   import codeword_deserializer_pkg::*;
#(
   parameter int WIDTH = CW_WIDTH
) ();

   localparam int IDX_W = $clog2(WIDTH);

   logic             in_valid;
   logic             in_bit;
   logic             in_sof;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_word;
   logic [IDX_W-1:0] bit_idx;
   logic             frame_err;

   modport master (
      output in_valid, in_bit, in_sof, out_ready,
      input  in_ready, out_valid, out_word, bit_idx, frame_err
   );

   modport slave (
      input  in_valid, in_bit, in_sof, out_ready,
      output in_ready, out_valid, out_word, bit_idx, frame_err
   );

endinterface

// File: rtl/codeword_deserializer.sv
// ---------------------------------------------------------------------------
// codeword_deserializer
// Collects one codeword bit per handshake into a WIDTH-bit word, bit k of a
// frame landing at word position k (LSB = first bit). in_sof marks bit 0;
// an in_sof mid-frame aborts and restarts, a non-sof bit in IDLE is dropped.
// Both cases pulse frame_err for one cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : codeword_deserializer_if.slave (serial in, word out, status)
// WIDTH legal range 2..16; all outputs are registered.
// ---------------------------------------------------------------------------
module codeword_deserializer
   import codeword_deserializer_pkg::*;
#(
   parameter int WIDTH = CW_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   codeword_deserializer_if.slave bus
);

   localparam int               IDX_W    = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   cw_state_t        state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             frame_err_q, frame_err_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic             xfer_in;
   logic             xfer_out;
   logic [WIDTH-1:0] wr_sel;

   assign xfer_in  = bus.in_valid && in_ready_q;
   assign xfer_out = out_valid_q && bus.out_ready;
   // one-hot write enable for the current bit position
   assign wr_sel   = WIDTH'(1) << idx_q;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         word_q      <= '0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
         word_q      <= word_d;
         idx_q       <= idx_d;
      end
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (xfer_in && bus.in_sof) state_d = COLLECT;
         COLLECT: if (xfer_in && !bus.in_sof && (idx_q == LAST_IDX)) state_d = HOLD;
         HOLD:    if (xfer_out) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      word_d      = word_q;
      idx_d       = idx_q;
      frame_err_d = 1'b0;
      // handshake flags are a decode of the upcoming state, so they are
      // registered and have no combinational path from out_ready
      in_ready_d  = (state_d != HOLD);
      out_valid_d = (state_d == HOLD);

      if (xfer_in) begin
         if (bus.in_sof) begin
            // fresh start from IDLE, or abort-and-restart from COLLECT:
            // unwritten positions must read as 0
            word_d      = WIDTH'(bus.in_bit);
            idx_d       = IDX_W'(1);
            frame_err_d = (state_q == COLLECT);
         end else if (state_q == IDLE) begin
            frame_err_d = 1'b1;
         end else begin
            word_d = bus.in_bit ? (word_q | wr_sel) : (word_q & ~wr_sel);
            idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_word  = word_q;
   assign bus.bit_idx   = idx_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_codeword_deserializer.sv
// ---------------------------------------------------------------------------
// tb_codeword_deserializer
// Directed scenarios followed by 200 randomised frames with input gaps,
// stray bits and output back-pressure, compared against a bit-queue model.
// ---------------------------------------------------------------------------
module tb_codeword_deserializer;
   import codeword_deserializer_pkg::*;

   localparam int W = CW_WIDTH;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   codeword_deserializer_if #(.WIDTH(W)) bus ();

   codeword_deserializer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b, input logic sof);
      bus.in_valid = 1'b1;
      bus.in_bit   = b;
      bus.in_sof   = sof;
      tick();
      bus.in_valid = 1'b0;
      bus.in_bit   = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic send_frame(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) begin
         send_bit(w[i], i == 0);
         check("frame_err_in_frame", bus.frame_err, 0);
         check("bit_idx_in_frame", bus.bit_idx, (i + 1) % W);
         check("out_valid_timing", bus.out_valid, i == W - 1);
      end
   endtask

   initial begin
      logic [W-1:0] w;
      logic [W-1:0] exp_w;
      logic         q[$];
      int           gap;
      int           hold;

      bus.in_valid  = 1'b0;
      bus.in_bit    = 1'b0;
      bus.in_sof    = 1'b0;
      bus.out_ready = 1'b0;

      // reset
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_word", bus.out_word, 0);
      check("rst_bit_idx", bus.bit_idx, 0);
      check("rst_frame_err", bus.frame_err, 0);
      rst_n = 1'b1;
      tick();

      // frame 0xA5C3 with out_ready high
      bus.out_ready = 1'b1;
      send_frame(16'hA5C3);
      check("f1_word", bus.out_word, 16'hA5C3);
      check("f1_in_ready_hold", bus.in_ready, 0);
      tick();
      check("f1_valid_one_cycle", bus.out_valid, 0);
      check("f1_in_ready_back", bus.in_ready, 1);
      check("f1_word_kept", bus.out_word, 16'hA5C3);

      // same frame, 5 cycles of back-pressure; bits offered in HOLD are ignored
      bus.out_ready = 1'b0;
      send_frame(16'hA5C3);
      for (int c = 0; c < 5; c++) begin
         bus.in_valid = 1'b1;
         bus.in_sof   = 1'b1;
         bus.in_bit   = 1'b1;
         tick();
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_out_word", bus.out_word, 16'hA5C3);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_frame_err", bus.frame_err, 0);
         check("bp_bit_idx", bus.bit_idx, 0);
      end
      bus.in_valid  = 1'b0;
      bus.in_sof    = 1'b0;
      bus.in_bit    = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("bp_release_valid", bus.out_valid, 0);
      check("bp_release_ready", bus.in_ready, 1);

      // stray bits from IDLE
      for (int i = 0; i < 3; i++) begin
         send_bit(1'b1, 1'b0);
         check("stray_frame_err", bus.frame_err, 1);
         check("stray_bit_idx", bus.bit_idx, 0);
         check("stray_out_valid", bus.out_valid, 0);
      end
      tick();
      check("stray_err_pulse_end", bus.frame_err, 0);

      // 7 bits, then a restart with in_bit=1 and 15 zeros
      for (int i = 0; i < 7; i++) begin
         send_bit(1'b1, i == 0);
         check("abort_pre_err", bus.frame_err, 0);
      end
      send_bit(1'b1, 1'b1);
      check("abort_err", bus.frame_err, 1);
      check("abort_idx", bus.bit_idx, 1);
      check("abort_word", bus.out_word, 16'h0001);
      for (int i = 1; i < W; i++) begin
         send_bit(1'b0, 1'b0);
         check("abort_post_err", bus.frame_err, 0);
      end
      check("abort_final_valid", bus.out_valid, 1);
      check("abort_final_word", bus.out_word, 16'h0001);
      tick();

      // reset after 10 bits, then a full 0xFFFF frame
      for (int i = 0; i < 10; i++) send_bit(1'b1, i == 0);
      check("mid_idx_before_rst", bus.bit_idx, 10);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_bit_idx", bus.bit_idx, 0);
      check("midrst_out_word", bus.out_word, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_frame_err", bus.frame_err, 0);
      send_frame(16'hFFFF);
      check("ffff_word", bus.out_word, 16'hFFFF);
      tick();

      // reset while holding a word
      bus.out_ready = 1'b0;
      send_frame(16'h1234);
      check("holdrst_pre_word", bus.out_word, 16'h1234);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("holdrst_out_valid", bus.out_valid, 0);
      check("holdrst_in_ready", bus.in_ready, 1);
      check("holdrst_out_word", bus.out_word, 0);

      // randomised frames against the bit-queue model
      for (int f = 0; f < 200; f++) begin
         w = W'($urandom);
         if ($urandom_range(7) == 0) begin
            send_bit(1'($urandom_range(1)), 1'b0);
            check("rnd_stray_err", bus.frame_err, 1);
            check("rnd_stray_idx", bus.bit_idx, 0);
         end
         check("rnd_ready_start", bus.in_ready, 1);
         q.delete();
         for (int i = 0; i < W; i++) begin
            gap = $urandom_range(3);
            for (int g = 0; g < gap; g++) begin
               bus.in_sof = 1'($urandom_range(1));
               bus.in_bit = 1'($urandom_range(1));
               tick();
               check("rnd_gap_idx", bus.bit_idx, q.size() % W);
               check("rnd_gap_err", bus.frame_err, 0);
            end
            bus.in_sof = 1'b0;
            q.push_back(w[i]);
            send_bit(w[i], i == 0);
            check("rnd_idx", bus.bit_idx, q.size() % W);
            check("rnd_err", bus.frame_err, 0);
         end
         exp_w = '0;
         foreach (q[j]) exp_w[j] = q[j];
         check("rnd_valid", bus.out_valid, 1);
         check("rnd_word", bus.out_word, exp_w);
         hold = $urandom_range(2);
         for (int h = 0; h < hold; h++) begin
            tick();
            check("rnd_hold_word", bus.out_word, exp_w);
            check("rnd_hold_valid", bus.out_valid, 1);
         end
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
         check("rnd_release_valid", bus.out_valid, 0);
         check("rnd_release_ready", bus.in_ready, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/codeword_deserializer.md
# codeword_deserializer

Serial-to-parallel collector for the self-correcting message path: accepts one codeword bit per handshake, places bit k of a frame at word position k, and presents the completed 16-bit Hamming codeword (15-bit Hamming plus overall parity) to the downstream decoder. It is the inverse of the 16:1 bit-select stage on the transmit side, where select value k drives word bit k onto the line. Frame alignment comes from a start-of-frame marker. Misaligned or truncated frames are flagged and discarded.

## Interface
- WIDTH, 16, codeword length in bits; legal values 2..16.
- IDX_W, 4, bit-index width, equal to clog2(WIDTH); derived, not overridden.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  serial bit present.
- in_bit  in  1  serial data bit.
- in_sof  in  1  qualifies in_bit as bit 0 of a new frame; meaningful only with in_valid.
- in_ready  out  1  block can accept a bit; registered.
- out_valid  out  1  out_word holds a complete frame.
- out_ready  in  1  downstream accepts out_word.
- out_word  out  WIDTH  assembled codeword, LSB = first bit received.
- bit_idx  out  IDX_W  index the next accepted bit will be written to.
- frame_err  out  1  one-cycle pulse: frame aborted or stray bit dropped.

## Operation
- An input transfer occurs when in_valid && in_ready at a rising edge. An output transfer occurs when out_valid && out_ready.
- The FSM has three states: IDLE, COLLECT, HOLD.
- IDLE: in_ready=1, bit_idx=0.
  - Transfer with in_sof=1: write in_bit to out_word[0] and set bit_idx=1. Go to COLLECT, or go directly to HOLD when WIDTH=1 (not legal).
  - Transfer with in_sof=0: drop the bit, pulse frame_err, stay in IDLE.
- COLLECT: in_ready=1.
  - Transfer with in_sof=0: write out_word[bit_idx], then increment bit_idx.
  - Transfer when bit_idx==WIDTH-1: write the last bit, wrap bit_idx to 0, set out_valid, go to HOLD.
  - Transfer with in_sof=1: abort the current frame and pulse frame_err. Clear out_word to 0, write in_bit to out_word[0], set bit_idx=1, stay in COLLECT. The new frame starts on this bit.
  - Cycles without a transfer hold all state. There is no timeout.
- HOLD: in_ready=0, out_valid=1, and out_word is stable.
  - On an output transfer: clear out_valid and go to IDLE. in_ready rises the following cycle. out_word keeps its value until the next frame's first bit.
- Bits not yet written in a frame read as 0. out_word is cleared on entry to COLLECT from IDLE.
- frame_err never pulses in HOLD, because no input transfer is possible there.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, in_ready=1 (takes effect at the first edge with rst_n low), out_valid=0, out_word=0, bit_idx=0, frame_err=0.
- Reset mid-frame discards the partial frame with no frame_err.
- Reset in HOLD drops out_valid at that edge.
- Latency: out_valid is high in the cycle after the edge that accepts bit WIDTH-1.
- Throughput: one frame per WIDTH+1 cycles minimum. The +1 is the HOLD to IDLE bubble, with out_ready tied high.
- frame_err is high for exactly the one cycle following the offending edge.
- in_ready is the registered state decode; no combinational path from out_ready to in_ready.

## Structure
- The shared package holds:
  - the state enum (IDLE, COLLECT, HOLD);
  - the CW_WIDTH=16 constant;
  - the CW_IDX_W=4 constant, shared with the transmit-side bit-select stage and the decoder.
- Single module, no sub-module. The bit counter and the write-enable decode (a one-hot of bit_idx) are inline.

## Test plan
- Reset, then feed 16 bits of 0xA5C3 LSB-first with in_sof on the first bit and out_ready=1. Required: out_word=0xA5C3 and out_valid for one cycle, 1 cycle after the 16th bit; frame_err never set.
- Same frame with out_ready=0 for 5 cycles after completion. Required: out_valid and out_word held stable and in_ready=0 throughout; in_ready=1 one cycle after the handshake.
- Send 3 bits with in_sof=0 from IDLE. Required: three frame_err pulses, bit_idx stays 0, no out_valid.
- Send 7 bits of a frame, then in_sof with in_bit=1 followed by 15 bits of 0. Required: one frame_err pulse, final out_word=0x0001.
- Assert rst_n=0 for one cycle after 10 bits. Required: the next edge shows bit_idx=0, out_word=0, IDLE state, no frame_err; a following full frame of 0xFFFF is collected correctly.
- Randomise in_valid gaps over 200 frames against a reference model. Required: every frame is bit-exact and bit_idx matches the bits accepted.
